// File: rtl/dot_product_acc.sv
// dot_product_acc: sums every LEN product beats into one result and queues
// results in a 2-entry valid/ready FIFO. Optional macro: DOT_ACC_LAST_EN.
module dot_product_acc #(
    parameter int PROD_W = 8,
    parameter int LEN    = 4,
    parameter int ACC_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
`ifdef DOT_ACC_LAST_EN
    input  logic              prod_last,
`endif
    input  logic              clear,
    output logic [ACC_W-1:0]  sum_out,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              overflow
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] head_q, head_d;
    logic [ACC_W-1:0] tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc_sum;
    logic             last_beat;
    logic             close_grp;
    logic             push;
    logic             pop;
    logic             drop;

    // Product widened (or trimmed) to the accumulator width.
    if (PROD_W >= ACC_W) begin : g_trim
        assign prod_ext = prod_in[ACC_W-1:0];
    end else begin : g_ext
        assign prod_ext = {{(ACC_W-PROD_W){1'b0}}, prod_in};
    end

`ifdef DOT_ACC_LAST_EN
    assign last_beat = prod_last;
`else
    assign last_beat = 1'b0;
`endif

    // Wrapping sum; also the value pushed on a closing beat.
    assign acc_sum   = acc_q + prod_ext;
    assign close_grp = (cnt_q == LAST_CNT) || last_beat;
    assign pop       = (occ_q != 2'd0) && sum_ready;

    // Group accumulation; clear wins over a coincident beat.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        push  = 1'b0;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (prod_valid) begin
            if (close_grp) begin
                push  = 1'b1;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Two-entry result queue; a pop frees a slot before the push lands.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        drop   = 1'b0;
        unique case (occ_q)
            2'd0: begin
                if (push) begin
                    head_d = acc_sum;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = acc_sum;
                end else if (push) begin
                    tail_d = acc_sum;
                    occ_d  = 2'd2;
                end else if (pop) begin
                    head_d = '0;
                    occ_d  = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d = tail_q;
                    tail_d = push ? acc_sum : '0;
                    occ_d  = push ? 2'd2 : 2'd1;
                end else if (push) begin
                    drop = 1'b1;
                end
            end
            default: begin
                head_d = '0;
                tail_d = '0;
                occ_d  = 2'd0;
            end
        endcase
    end

    // Sticky overflow: set by a dropped result, cleared only by clear.
    always_comb begin
        ovf_d = ovf_q;
        if (clear) begin
            ovf_d = 1'b0;
        end else if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
            ovf_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            ovf_q  <= ovf_d;
        end
    end

    // Head register is zeroed whenever the queue drains, so it is the output.
    assign sum_out   = head_q;
    assign sum_valid = (occ_q != 2'd0);
    assign overflow  = ovf_q;

endmodule

// File: doc/dot_product_acc.md
Name: dot_product_acc

Overview:
- Downstream consumer of the repeated-addition multiplier (multiplication_algo).
- Sums every LEN consecutive products into one dot-product result.
- Buffers completed results in a 2-entry output queue with valid/ready handshake to the next stage.
- The multiplier's output has no backpressure, so this block accepts a product beat on every cycle without exception.

Parameters:
- PROD_W, 8, width of incoming product (matches multiplier mult_out).
- LEN, 4, number of products per result; legal range 2..16.
- ACC_W, 10, accumulator/result width; sums wrap modulo 2^ACC_W.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- prod_in  input  PROD_W  product from multiplier mult_out.
- prod_valid  input  1  product beat present (multiplier valid_out); always accepted.
- clear  input  1  synchronous restart of the current group and clear of overflow.
- sum_out  output  ACC_W  head-of-queue result.
- sum_valid  output  1  queue non-empty.
- sum_ready  input  1  downstream accepts head.
- overflow  output  1  sticky: a completed result was dropped.

Behaviour:
- Reset (rst_n low, asynchronous): acc=0, beat count=0, queue empty, sum_valid=0, sum_out=0, overflow=0. Applies mid-group; the partial sum is discarded.
- Arithmetic: prod_in zero-extended to ACC_W; acc_next = acc + prod_in, truncated to ACC_W bits (wrap, no saturation).
- Group counter runs 0..LEN-1.
  - On prod_valid with count<LEN-1: acc <= acc_next, count++.
  - On prod_valid with count==LEN-1 (closing beat): push acc_next into queue, acc <= 0, count <= 0.
- Latency: a result pushed at edge N gives sum_valid=1 after edge N (registered output, no combinational path from prod_in to sum_out).
- Queue: 2 entries, FIFO order.
  - sum_valid = queue non-empty.
  - sum_out = head entry, driven to 0 when empty.
  - Pop occurs when sum_valid && sum_ready at a posedge.
  - sum_out and sum_valid must stay stable while sum_valid && !sum_ready.
- Simultaneous push and pop:
  - Queue empty: no pop; push only.
  - 1 entry: both proceed; count stays 1.
  - Full: pop frees a slot first; the push is stored; no overflow.
- Push when full without pop: the new result is dropped, the queue is unchanged, and overflow <= 1. overflow remains set until reset or clear.
- clear (sync, priority over prod_valid):
  - acc <= 0, count <= 0, overflow <= 0.
  - A coincident prod_valid beat is discarded.
  - Queue contents and any pop in the same cycle are unaffected.
- The group count is not observable; verification infers it from result timing.

Optional Feature:
- Macro: DOT_ACC_LAST_EN.
- Defined:
  - Adds input port prod_last (1 bit), sampled only with prod_valid.
  - A beat with prod_last=1 closes the group regardless of count: it pushes acc_next and resets acc and count, with the same queue/overflow rules.
  - A beat that is both prod_last and the LEN-th beat closes one group only.
- Not defined: port is absent; groups are always exactly LEN beats.

Test Plan:
- Basic group: LEN=4, sum_ready=1, prod_in 10,30,15,2 on consecutive cycles -> single sum_valid pulse with sum_out=57 (0x039) the cycle after the 4th beat; overflow=0.
- Backpressure/overflow: sum_ready=0, three groups of 4x 1 -> two queued entries of 4, third dropped, overflow=1. Then raise sum_ready -> two results of 4 in order, then sum_valid=0; overflow stays 1 until clear pulse.
- Full push+pop: queue full with 4, 8; sum_ready=1 on the same edge as closing beat of group summing 12 -> pops 4, queue holds 8, 12; overflow=0.
- Max values/wrap: four beats of 0xFF -> 1020 (0x3FC). Override ACC_W=8 -> same stimulus gives 0xFC.
- Reset and clear mid-group:
  - Two beats of 50, then rst_n low for one cycle, then 1,2,3,4 -> result 10.
  - Repeat with clear asserted together with a beat of 99 instead of reset -> result 10; the 99 beat is ignored.
- DOT_ACC_LAST_EN: beats 5,6 with prod_last on 6 -> result 11; next 4 beats of 2 -> result 8.
